wptr_handler: RTL and testbench
===============================

Name: wptr_handler

Overview:
Write-domain pointer/flag stage of the async FIFO. It sits upstream of the memory and feeds the read-side pointer handler through the gray pointer CDC path. It advances the binary/gray write pointer on accepted writes and generates full, almost-full, write level and a sticky overflow flag. Its input is the read gray pointer after the 2-flop synchronizer into wclk.

Parameters:
P_PTR_W, 4, pointer width = address width + 1 (FIFO depth = 2^(P_PTR_W-1)); legal range >= 3
P_AFULL_TH, 6, almost-full threshold in entries; legal range 1 .. 2^(P_PTR_W-1)

Ports:
wclk  input  1  write-domain clock
wrst  input  1  synchronous reset, active-high
i_w_en  input  1  write request
i_g_rptr_sync  input  P_PTR_W  read gray pointer, already synchronized to wclk
i_ovf_clr  input  1  clear for sticky overflow flag
o_wr_ok  output  1  memory write enable (combinational)
o_b_wptr  output  P_PTR_W  binary write pointer; [P_PTR_W-2:0] is the memory write address
o_g_wptr  output  P_PTR_W  gray write pointer, sent to the read-domain synchronizer
o_full  output  1  FIFO full
o_afull  output  1  level >= P_AFULL_TH
o_wlevel  output  P_PTR_W  occupancy seen from the write side, 0 .. depth
o_ovf  output  1  sticky: a write was attempted while full

Behaviour:
- Clock and reset: single clock wclk. wrst is synchronous and active-high.
- Reset: while wrst=1 at a wclk edge, every registered output goes to 0 (o_b_wptr, o_g_wptr, o_full, o_afull, o_wlevel, o_ovf). A write in that cycle is ignored. Reset mid-operation (including while full) takes effect at the next edge with no residual state.
- Write acceptance: o_wr_ok = i_w_en & ~o_full, combinational, same cycle as the request.
- Binary pointer: b_nxt = o_b_wptr + o_wr_ok, modulo 2^P_PTR_W, so it wraps 2^P_PTR_W-1 -> 0.
- Gray pointer: g_nxt = b_nxt ^ (b_nxt >> 1). o_g_wptr is registered, so at most one bit changes per edge.
- Full: full_nxt = (g_nxt == {~i_g_rptr_sync[W-1:W-2], i_g_rptr_sync[W-3:0]}), with W = P_PTR_W.
- Read-pointer conversion: b_rsync = gray2bin(i_g_rptr_sync), where b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i].
- Level: level_nxt = b_nxt - b_rsync, modulo 2^W. The value never exceeds 2^(W-1).
- Almost-full: afull_nxt = (level_nxt >= P_AFULL_TH).
- Register update: o_b_wptr, o_g_wptr, o_full, o_afull and o_wlevel take their _nxt values every non-reset edge.
- Flag latency: the write that fills the last entry raises o_full at that same edge, so the next cycle is already blocked.
- Flag release: flags are conservative. A read becomes visible only after synchronizer delay, and full/level update at the first edge after i_g_rptr_sync changes.
- Simultaneous events: a write and a read-pointer advance in the same cycle leave the level unchanged. full_nxt is evaluated on the combined result.
- Overflow: o_ovf sets on (i_w_en & o_full). It clears on i_ovf_clr. If set and clear occur in the same cycle, set wins. o_ovf holds otherwise.
- No state machine; the block is purely counter/compare datapath with registered flags.

Decomposition:
- Package fifo_pkg:
  - functions bin2gray and gray2bin (width-generic via parameterized usage)
  - a default pointer-width constant shared with the read-side pointer handler
- No sub-module: gray2bin is a package function, not an instance. The synchronizer stays outside this block.

Test Plan:
Test plan values use W=4 (depth 8) and TH=6.
1. Reset: hold wrst=1 for 2 edges with i_w_en=1 -> all outputs 0; o_wr_ok stays 1 only combinationally and no pointer moves.
2. Fill: i_g_rptr_sync=0, i_w_en=1 for 8 edges.
   - o_afull=1 after the 6th edge (level 6).
   - After the 8th edge: o_b_wptr=8, o_g_wptr=4'b1100, o_full=1, o_wlevel=8.
3. Overflow: keep i_w_en=1 while full.
   - o_wr_ok=0, o_b_wptr stays 8, o_ovf=1 next edge.
   - A pulse on i_ovf_clr alone -> o_ovf=0.
   - i_ovf_clr together with a blocked write -> o_ovf stays 1.
4. Release: from full, drive i_g_rptr_sync=4'b0001 (bin 1) -> next edge o_full=0, o_wlevel=7, o_afull=1. Then drive 4'b0010 (bin 3) -> o_wlevel=5, o_afull=0.
5. Wrap: advance the pointers until o_b_wptr goes 15 -> 0.
   - o_g_wptr goes 4'b1000 -> 4'b0000 and o_wlevel stays correct mod 16.
   - With rsync at bin 11 (4'b1110), writing until o_b_wptr=3 (4'b0010) -> o_full=1, o_wlevel=8.
6. Simultaneous: at o_wlevel=7, assert i_w_en=1 and advance i_g_rptr_sync by one in the same cycle -> o_wlevel stays 7, o_full=0, o_b_wptr increments. Then assert wrst mid-stream -> all outputs 0 next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer-width default and gray/binary conversion.
// Functions work at a fixed maximum width; callers zero-extend narrower pointers.
package fifo_pkg;

    localparam int C_PTR_W     = 4;
    localparam int C_MAX_PTR_W = 32;

    // Zero bits above the real width do not disturb either conversion.
    function automatic logic [C_MAX_PTR_W-1:0] bin2gray(input logic [C_MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [C_MAX_PTR_W-1:0] gray2bin(input logic [C_MAX_PTR_W-1:0] g);
        logic [C_MAX_PTR_W-1:0] b;
        b[C_MAX_PTR_W-1] = g[C_MAX_PTR_W-1];
        for (int i = C_MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_handler.sv
// Write-side pointer/flag stage of the async FIFO: binary/gray write pointer,
// full, almost-full, write-side level and sticky overflow.
module wptr_handler
    import fifo_pkg::*;
#(
    parameter int P_PTR_W    = C_PTR_W,
    parameter int P_AFULL_TH = 6
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic               i_w_en,
    input  logic [P_PTR_W-1:0] i_g_rptr_sync,
    input  logic               i_ovf_clr,
    output logic               o_wr_ok,
    output logic [P_PTR_W-1:0] o_b_wptr,
    output logic [P_PTR_W-1:0] o_g_wptr,
    output logic               o_full,
    output logic               o_afull,
    output logic [P_PTR_W-1:0] o_wlevel,
    output logic               o_ovf
);

    localparam int W = P_PTR_W;
    localparam logic [W-1:0] C_TH = W'(P_AFULL_TH);

    logic [W-1:0]           b_nxt;
    logic [W-1:0]           g_nxt;
    logic [W-1:0]           b_rsync;
    logic [W-1:0]           level_nxt;
    logic [W-1:0]           rptr_full_cmp;
    logic [C_MAX_PTR_W-1:0] g_nxt_wide;
    logic [C_MAX_PTR_W-1:0] b_rsync_wide;
    logic                   full_nxt;
    logic                   afull_nxt;

    assign o_wr_ok = i_w_en & ~o_full;

    always_comb begin
        b_nxt         = o_b_wptr + {{(W-1){1'b0}}, o_wr_ok};
        g_nxt_wide    = bin2gray({{(C_MAX_PTR_W-W){1'b0}}, b_nxt});
        g_nxt         = g_nxt_wide[W-1:0];
        b_rsync_wide  = gray2bin({{(C_MAX_PTR_W-W){1'b0}}, i_g_rptr_sync});
        b_rsync       = b_rsync_wide[W-1:0];
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        rptr_full_cmp = {~i_g_rptr_sync[W-1:W-2], i_g_rptr_sync[W-3:0]};
        full_nxt      = (g_nxt == rptr_full_cmp);
        level_nxt     = b_nxt - b_rsync;
        afull_nxt     = (level_nxt >= C_TH);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            o_b_wptr <= '0;
            o_g_wptr <= '0;
            o_full   <= 1'b0;
            o_afull  <= 1'b0;
            o_wlevel <= '0;
            o_ovf    <= 1'b0;
        end else begin
            o_b_wptr <= b_nxt;
            o_g_wptr <= g_nxt;
            o_full   <= full_nxt;
            o_afull  <= afull_nxt;
            o_wlevel <= level_nxt;
            // A blocked write in the same cycle as a clear keeps the flag set.
            if (i_w_en && o_full) begin
                o_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                o_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_handler.sv
// Directed bench for wptr_handler at W=4 (depth 8), almost-full threshold 6.
module tb_wptr_handler;

    localparam int W = 4;

    logic         wclk = 1'b0;
    logic         wrst;
    logic         i_w_en;
    logic [W-1:0] i_g_rptr_sync;
    logic         i_ovf_clr;
    logic         o_wr_ok;
    logic [W-1:0] o_b_wptr;
    logic [W-1:0] o_g_wptr;
    logic         o_full;
    logic         o_afull;
    logic [W-1:0] o_wlevel;
    logic         o_ovf;

    int checks   = 0;
    int failures = 0;

    wptr_handler #(.P_PTR_W(W), .P_AFULL_TH(6)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .i_w_en       (i_w_en),
        .i_g_rptr_sync(i_g_rptr_sync),
        .i_ovf_clr    (i_ovf_clr),
        .o_wr_ok      (o_wr_ok),
        .o_b_wptr     (o_b_wptr),
        .o_g_wptr     (o_g_wptr),
        .o_full       (o_full),
        .o_afull      (o_afull),
        .o_wlevel     (o_wlevel),
        .o_ovf        (o_ovf)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge wclk);
        @(negedge wclk);
    endtask

    initial begin
        wrst          = 1'b1;
        i_w_en        = 1'b1;
        i_g_rptr_sync = 4'b0000;
        i_ovf_clr     = 1'b0;
        @(negedge wclk);
        step();
        step();
        check("rst_b_wptr", 32'(o_b_wptr), 0);
        check("rst_g_wptr", 32'(o_g_wptr), 0);
        check("rst_full",   32'(o_full),   0);
        check("rst_afull",  32'(o_afull),  0);
        check("rst_wlevel", 32'(o_wlevel), 0);
        check("rst_ovf",    32'(o_ovf),    0);
        check("rst_wr_ok",  32'(o_wr_ok),  1);

        wrst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("fill_b_wptr", 32'(o_b_wptr), 32'(k));
            if (k == 5) check("fill_afull_l5", 32'(o_afull), 0);
            if (k == 6) check("fill_afull_l6", 32'(o_afull), 1);
        end
        check("fill_g_wptr", 32'(o_g_wptr), 32'h0C);
        check("fill_full",   32'(o_full),   1);
        check("fill_wlevel", 32'(o_wlevel), 8);

        check("ovf_wr_ok", 32'(o_wr_ok), 0);
        step();
        check("ovf_b_hold", 32'(o_b_wptr), 8);
        check("ovf_set",    32'(o_ovf),    1);
        i_w_en    = 1'b0;
        i_ovf_clr = 1'b1;
        step();
        check("ovf_clr", 32'(o_ovf), 0);
        i_w_en = 1'b1;
        step();
        check("ovf_set_wins", 32'(o_ovf), 1);

        i_w_en        = 1'b0;
        i_ovf_clr     = 1'b0;
        i_g_rptr_sync = 4'b0001;
        step();
        check("rel1_full",   32'(o_full),   0);
        check("rel1_wlevel", 32'(o_wlevel), 7);
        check("rel1_afull",  32'(o_afull),  1);
        i_g_rptr_sync = 4'b0010;
        step();
        check("rel2_wlevel", 32'(o_wlevel), 5);
        check("rel2_afull",  32'(o_afull),  0);

        i_g_rptr_sync = 4'b1100;
        step();
        check("wrap_empty_level", 32'(o_wlevel), 0);
        i_w_en = 1'b1;
        for (int k = 0; k < 7; k++) step();
        check("wrap_b15",     32'(o_b_wptr), 15);
        check("wrap_g15",     32'(o_g_wptr), 32'h08);
        check("wrap_level7",  32'(o_wlevel), 7);
        check("wrap_afull7",  32'(o_afull),  1);
        i_g_rptr_sync = 4'b1110;
        step();
        check("wrap_b0",      32'(o_b_wptr), 0);
        check("wrap_g0",      32'(o_g_wptr), 0);
        check("wrap_level5",  32'(o_wlevel), 5);
        check("wrap_full0",   32'(o_full),   0);
        for (int k = 0; k < 3; k++) step();
        check("wrap_b3",      32'(o_b_wptr), 3);
        check("wrap_g3",      32'(o_g_wptr), 32'h02);
        check("wrap_full",    32'(o_full),   1);
        check("wrap_level8",  32'(o_wlevel), 8);

        i_w_en        = 1'b0;
        i_g_rptr_sync = 4'b1010;
        step();
        check("sim_pre_level", 32'(o_wlevel), 7);
        check("sim_pre_full",  32'(o_full),   0);
        i_w_en        = 1'b1;
        i_g_rptr_sync = 4'b1011;
        step();
        check("sim_b_wptr", 32'(o_b_wptr), 4);
        check("sim_level",  32'(o_wlevel), 7);
        check("sim_full",   32'(o_full),   0);
        check("sim_ovf_held", 32'(o_ovf),  1);

        wrst = 1'b1;
        step();
        check("mid_rst_b_wptr", 32'(o_b_wptr), 0);
        check("mid_rst_g_wptr", 32'(o_g_wptr), 0);
        check("mid_rst_full",   32'(o_full),   0);
        check("mid_rst_afull",  32'(o_afull),  0);
        check("mid_rst_wlevel", 32'(o_wlevel), 0);
        check("mid_rst_ovf",    32'(o_ovf),    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
